// File: rtl/uart_rx_fifo.sv
// Receive-side synchronous FIFO between the UART receiver and the host reader.
// First-word-fall-through read port, occupancy/almost-full status and sticky error flags.
module uart_rx_fifo #(
    parameter int unsigned D_W      = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [D_W-1:0]           wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [D_W-1:0]           rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     underrun,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [D_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic           wr_ok;
    logic           rd_ok;
    logic [CW-1:0]  count_nxt;

    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rp];

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= wr_data;
        end
    end

    // Flags are registered from the next occupancy so they equal a decode of count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= wp + AW'(1);
            end
            if (rd_ok) begin
                rp <= rp + AW'(1);
            end
            count       <= count_nxt;
            full        <= (count_nxt == CW'(DEPTH));
            empty       <= (count_nxt == CW'(0));
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
            overrun     <= (wr_en & full) | (overrun & ~clr_err);
            underrun    <= (rd_en & empty) | (underrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of single-cycle vectors followed by
// directed sequences for fill/overflow, wrap-around, simultaneous access and mid-op reset.
module tb_uart_rx_fifo;

    localparam int unsigned D_W      = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 12;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic [D_W-1:0]        wr_data = '0;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en = 1'b0;
    logic [D_W-1:0]        rd_data;
    logic                  empty;
    logic [$clog2(DEPTH):0] count;
    logic                  overrun;
    logic                  underrun;
    logic                  clr_err = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.D_W(D_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .count(count), .overrun(overrun), .underrun(underrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ovr;
        logic       udr;
        logic       dchk;
        logic [7:0] data;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_status(input string nm, input int cnt, input logic emp, input logic ful,
                              input logic af, input logic ovr, input logic udr);
        chk({nm, ".count"}, 32'(count), 32'(cnt));
        chk({nm, ".empty"}, 32'(empty), 32'(emp));
        chk({nm, ".full"}, 32'(full), 32'(ful));
        chk({nm, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({nm, ".overrun"}, 32'(overrun), 32'(ovr));
        chk({nm, ".underrun"}, 32'(underrun), 32'(udr));
    endtask

    // One clock: inputs are held across the rising edge, then released 2ns later.
    task automatic apply(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        #2;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset for 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            apply(vt[i].wr, vt[i].wd, vt[i].rd, vt[i].clr);
            chk_status($sformatf("vec%0d", i), vt[i].cnt, vt[i].emp, vt[i].ful,
                       vt[i].af, vt[i].ovr, vt[i].udr);
            if (vt[i].dchk) chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vt[i].data));
        end

        // Fill 0x00..0x0F, then overflow with 0xFF
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 8'(i), 1'b0, 1'b0);
            chk_status($sformatf("fill%0d", i), i + 1, 1'b0, (i == 15), (i + 1 >= 12), 1'b0, 1'b0);
            chk("fill.head", 32'(rd_data), 32'h00);
        end
        apply(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_status("overflow", 16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(i));
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d.count", i), 32'(count), 32'(15 - i));
        end
        chk_status("drained", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("clr_ovr", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap-around: 10 in/out, then 12 bytes across the pointer wrap
        for (int i = 0; i < 10; i++) apply(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrapA%0d.rd_data", i), 32'(rd_data), 32'(8'h40 + i));
            apply(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            chk($sformatf("wrapW%0d.count", i), 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrapR%0d.rd_data", i), 32'(rd_data), 32'(8'h30 + i));
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("wrapR%0d.count", i), 32'(count), 32'(11 - i));
        end
        chk_status("wrap_end", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous read/write at count=1
        apply(1'b1, 8'h11, 1'b0, 1'b0);
        chk("sim1.head", 32'(rd_data), 32'h11);
        apply(1'b1, 8'h22, 1'b1, 1'b0);
        chk_status("sim1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim1.rd_data", 32'(rd_data), 32'h22);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("sim1_pop", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous read/write at count=DEPTH: write dropped, read accepted
        for (int i = 0; i < 16; i++) apply(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk_status("simF_pre", 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 8'h99, 1'b1, 1'b0);
        chk_status("simF", 15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("simF_drain%0d", i), 32'(rd_data), 32'(8'h50 + i));
            apply(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_status("simF_end", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous read/write at count=DEPTH-1
        for (int i = 0; i < 15; i++) apply(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        apply(1'b1, 8'h6F, 1'b1, 1'b0);
        chk_status("simE", 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("simE.rd_data", 32'(rd_data), 32'h61);
        for (int i = 0; i < 15; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("simE_end", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation with data stored and a write in flight
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk_status("pre_rst", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        #3;
        rst = 1'b1;
        #1;
        chk_status("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        apply(1'b1, 8'h5A, 1'b0, 1'b0);
        chk_status("post_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst.rd_data", 32'(rd_data), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side synchronous FIFO that buffers bytes written by the UART receiver (`ff_wr_en` / `out_data`) and presents them to the host-side reader. It reports `full` back to the receiver, which holds off writes while it is asserted. It also keeps occupancy, almost-full and sticky error status for the host. Single clock domain (`clk`); first-word-fall-through read port.

## Interface
- `D_W`, 8: data width in bits.
- `DEPTH`, 16: number of entries; must be a power of two and at least 2.
- `AF_LEVEL`, 12: `almost_full` asserts when `count` ≥ `AF_LEVEL`; legal range 1..`DEPTH`.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write request; connects to the receiver's `ff_wr_en`.
- `wr_data`  in  `D_W`: write data; connects to the receiver's `out_data`.
- `full`  out  1: FIFO full; connects to the receiver's `ff_full`.
- `almost_full`  out  1: `count` ≥ `AF_LEVEL`.
- `rd_en`  in  1: pop request from the reader.
- `rd_data`  out  `D_W`: head entry; valid whenever `empty` = 0.
- `empty`  out  1: FIFO empty.
- `count`  out  `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `overrun`  out  1: sticky; set when a write is dropped.
- `underrun`  out  1: sticky; set when a pop is requested while empty.
- `clr_err`  in  1: single-cycle pulse that clears `overrun` and `underrun`.

## Operation
- Storage: `DEPTH` × `D_W` register array, addressed by write pointer `wp` and read pointer `rp`.
  - Pointer width is `$clog2(DEPTH)`.
  - Pointers wrap naturally from `DEPTH-1` to 0.
  - Occupancy is tracked by the registered `count`.
- Write accepted iff `wr_en`=1 and `full`=0 at the clock edge.
  - Effect: `mem[wp]` ← `wr_data`; `wp` increments.
- Read accepted iff `rd_en`=1 and `empty`=0 at the clock edge.
  - Effect: `rp` increments.
- `count` update on each edge:
  - +1 on an accepted write alone.
  - −1 on an accepted read alone.
  - Unchanged when both are accepted, or when neither is.
- Flag decoding from registered `count`:
  - `full` = (`count` == `DEPTH`).
  - `empty` = (`count` == 0).
  - `almost_full` = (`count` ≥ `AF_LEVEL`).
- `rd_data` = `mem[rp]` (combinational read); its value is don't-care while `empty`=1.
- Boundary cases:
  - **Write when full:** dropped, regardless of `rd_en`. Memory, `wp` and `count` are unchanged except for any accepted read. `overrun` ← 1.
  - **Read when empty:** ignored, even if a write is accepted in the same cycle. `underrun` ← 1.
  - **Simultaneous read and write at `count`=1:** both accepted. `count` stays 1 and `rd_data` moves to the new entry.
  - **Simultaneous read and write at `count`=`DEPTH`-1:** both accepted; `count` stays `DEPTH`-1.
- Error flag update priority on each edge: a set condition wins over `clr_err`. A flag stays 1 if an error occurs in the same cycle as `clr_err`.

## Timing
- Reset values:
  - `wp`=`rp`=0, `count`=0.
  - `empty`=1, `full`=0, `almost_full`=0 (with `AF_LEVEL`≥1).
  - `overrun`=0, `underrun`=0.
  - Memory contents are not reset; `rd_data` is don't-care.
- Reset mid-operation discards all stored data immediately (asynchronous). Normal operation resumes on the first edge after `rst` deasserts.
- Write-to-read latency: after a write into an empty FIFO at edge N, `empty` falls and `rd_data` holds the written byte during cycle N+1. A read may then be accepted at edge N+1.
- A pop at edge N presents the next entry on `rd_data` during cycle N+1.
- All status outputs (`full`, `empty`, `almost_full`, `count`, error flags) change only after a clock edge; none is combinational from the inputs.
- Receiver handshake: `full` is observed by the receiver before it raises `ff_wr_en`.
  - A single-cycle `wr_en` pulse per byte is the normal case.
  - A `wr_en` held high for k cycles writes k entries, stopping at full and setting `overrun` after that.

## Test plan
- **Reset then single byte:** assert `rst` for 3 cycles; write 0xA5.
  - Next cycle: `empty`=0, `count`=1, `rd_data`=0xA5.
  - After pop: `empty`=1, `count`=0, no error flags.
- **Fill, overflow and drain** (`DEPTH`=16, `AF_LEVEL`=12): write 0x00..0x0F, then write 0xFF.
  - `almost_full` rises when `count` reaches 12.
  - `full`=1 at `count`=16.
  - The 0xFF write sets `overrun`=1 and `count` stays 16.
  - Draining returns 0x00..0x0F in order, and 0xFF never appears.
- **Wrap-around:** write 10, read 10, then write 0x30..0x3B (12 bytes) and read them back.
  - Data order is correct across the pointer wrap.
  - `count` tracks exactly at every cycle.
- **Simultaneous read and write:**
  - At `count`=1 (head 0x11), write 0x22 with pop: `count` stays 1 and `rd_data`=0x22.
  - At `count`=16, write 0x99 with pop: 0x99 is dropped, `overrun`=1, `count`=15.
- **Underrun and clear:** pop while empty sets `underrun`=1 with `count`=0.
  - `clr_err` pulse clears it.
  - `clr_err` in the same cycle as a new empty pop leaves `underrun`=1.
- **Reset mid-operation:** with 5 bytes stored and a write in flight, pulse `rst` asynchronously between edges.
  - Outputs go immediately to their reset values: `count`=0, `empty`=1, flags 0.
  - The next write of 0x5A reads back as 0x5A.
